// File: rtl/bcd_to_xs3.sv
// bcd_to_xs3: registered per-digit converter between BCD and excess-3 code.
//   dir = 0 : BCD -> XS-3, adds 3. Inputs 10..15 are illegal.
//   dir = 1 : XS-3 -> BCD, subtracts 3. Inputs 0..2 and 13..15 are illegal.
//   An illegal input produces 0000 with err set. The latency is one cycle and
//   there is no backpressure.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high
//   in_valid   in   input digit {a,b,c,d} presented this cycle
//   dir        in   conversion direction, sampled with in_valid
//   a,b,c,d    in   input digit, a is the MSB
//   w,x,y,z    out  converted digit, w is the MSB
//   out_valid  out  w..z and err hold a fresh result this cycle
//   err        out  last accepted input was illegal for its direction
module bcd_to_xs3 (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic dir,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic w,
  output logic x,
  output logic y,
  output logic z,
  output logic out_valid,
  output logic err
);

  logic [3:0] w_code;
  logic [3:0] w_res;
  logic       w_illegal;

  logic [3:0] r_res;
  logic       r_valid;
  logic       r_err;

  assign w_code = {a, b, c, d};

  // A legal code never wraps, so plain 4-bit add and subtract are exact.
  always_comb begin
    w_res     = 4'b0000;
    w_illegal = 1'b0;
    if (!dir) begin
      if (w_code <= 4'd9) begin
        w_res = w_code + 4'd3;
      end else begin
        w_illegal = 1'b1;
      end
    end else begin
      if ((w_code >= 4'd3) && (w_code <= 4'd12)) begin
        w_res = w_code - 4'd3;
      end else begin
        w_illegal = 1'b1;
      end
    end
  end

  // The result and err hold across idle cycles. Only out_valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res   <= 4'b0000;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_res <= w_res;
        r_err <= w_illegal;
      end
    end
  end

  assign {w, x, y, z} = r_res;
  assign out_valid    = r_valid;
  assign err          = r_err;

endmodule

// File: tb/tb_bcd_to_xs3.sv
module tb_bcd_to_xs3;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic dir;
  logic a, b, c, d;
  logic w, x, y, z;
  logic out_valid;
  logic err;

  int n_vec = 0;
  int n_bad = 0;

  // Each entry is the expected value of {w,x,y,z,err}.
  logic [4:0] exp_q[$];

  bcd_to_xs3 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .dir      (dir),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .w        (w),
    .x        (x),
    .y        (y),
    .z        (z),
    .out_valid(out_valid),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic dr, input logic [3:0] n);
    in_valid     = 1'b1;
    dir          = dr;
    {a, b, c, d} = n;
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    in_valid = 1'b0;
    dir      = 1'b0;
    {a, b, c, d} = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({w, x, y, z, err, out_valid} !== 6'b000000) begin
        n_bad++;
        $display("FAIL reset[%0d]: got wxyz=%b err=%b v=%b, want 0000 0 0",
                 i, {w, x, y, z}, err, out_valid);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [3:0] ins [8];
    logic [3:0] outs[8];
    logic [4:0] e;
    ins  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9};
    outs = '{4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1011, 4'b1100};
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, ins[i]);
      exp_q.push_back({outs[i], 1'b0});
      @(posedge clk); #1;
      n_vec++;
      e = exp_q.pop_front();
      if (out_valid !== 1'b1 || {w, x, y, z, err} !== e) begin
        n_bad++;
        $display("FAIL fwd n=%0d: got v=%b wxyz=%b err=%b, want v=1 wxyz=%b err=%b",
                 ins[i], out_valid, {w, x, y, z}, err, e[4:1], e[0]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_illegal_fwd;
    logic [3:0] ins [3];
    logic [4:0] exps[3];
    logic [4:0] e;
    ins  = '{4'b1010, 4'b1111, 4'b0111};
    exps = '{5'b00001, 5'b00001, 5'b10100};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, ins[i]);
      exp_q.push_back(exps[i]);
      @(posedge clk); #1;
      n_vec++;
      e = exp_q.pop_front();
      if (out_valid !== 1'b1 || {w, x, y, z, err} !== e) begin
        n_bad++;
        $display("FAIL fwd_illegal n=%b: got v=%b wxyz=%b err=%b, want v=1 wxyz=%b err=%b",
                 ins[i], out_valid, {w, x, y, z}, err, e[4:1], e[0]);
      end
    end
    // With no input, out_valid drops and the last result holds.
    in_valid = 1'b0;
    {a, b, c, d} = 4'b0000;
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0 || {w, x, y, z, err} !== 5'b10100) begin
      n_bad++;
      $display("FAIL idle_hold: got v=%b wxyz=%b err=%b, want v=0 wxyz=1010 err=0",
               out_valid, {w, x, y, z}, err);
    end
  endtask

  task automatic test_xs3_to_bcd;
    logic [3:0] ins [5];
    logic [4:0] exps[5];
    logic [4:0] e;
    ins  = '{4'b0011, 4'b1100, 4'b0110, 4'b0010, 4'b1101};
    exps = '{5'b00000, 5'b10010, 5'b00110, 5'b00001, 5'b00001};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ins[i]);
      exp_q.push_back(exps[i]);
      @(posedge clk); #1;
      n_vec++;
      e = exp_q.pop_front();
      if (out_valid !== 1'b1 || {w, x, y, z, err} !== e) begin
        n_bad++;
        $display("FAIL rev n=%b: got v=%b wxyz=%b err=%b, want v=1 wxyz=%b err=%b",
                 ins[i], out_valid, {w, x, y, z}, err, e[4:1], e[0]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_round_trip;
    logic [3:0] dg;
    logic [4:0] e;
    for (int i = 0; i < 10; i++) begin
      dg = 4'(i);
      drive(1'b0, dg);
      exp_q.push_back({4'(i + 3), 1'b0});
      @(posedge clk); #1;
      n_vec++;
      e = exp_q.pop_front();
      if (out_valid !== 1'b1 || {w, x, y, z, err} !== e) begin
        n_bad++;
        $display("FAIL trip_fwd d=%0d: got v=%b wxyz=%b err=%b, want v=1 wxyz=%b err=0",
                 i, out_valid, {w, x, y, z}, err, e[4:1]);
      end
      // Feed the DUT's own XS-3 result straight back, back-to-back.
      drive(1'b1, {w, x, y, z});
      exp_q.push_back({dg, 1'b0});
      @(posedge clk); #1;
      n_vec++;
      e = exp_q.pop_front();
      if (out_valid !== 1'b1 || {w, x, y, z, err} !== e) begin
        n_bad++;
        $display("FAIL trip_rev d=%0d: got v=%b wxyz=%b err=%b, want v=1 wxyz=%b err=0",
                 i, out_valid, {w, x, y, z}, err, e[4:1]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midstream;
    logic [4:0] e;
    drive(1'b0, 4'b0101);
    exp_q.push_back(5'b10000);
    @(posedge clk); #1;
    n_vec++;
    e = exp_q.pop_front();
    if (out_valid !== 1'b1 || {w, x, y, z, err} !== e) begin
      n_bad++;
      $display("FAIL pre_rst: got v=%b wxyz=%b err=%b, want v=1 wxyz=1000 err=0",
               out_valid, {w, x, y, z}, err);
    end
    // in_valid is held high through the reset edge: reset must win.
    rst = 1'b1;
    {a, b, c, d} = 4'b0110;
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0 || {w, x, y, z, err} !== 5'b00000) begin
      n_bad++;
      $display("FAIL mid_rst: got v=%b wxyz=%b err=%b, want v=0 wxyz=0000 err=0",
               out_valid, {w, x, y, z}, err);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b0 || {w, x, y, z, err} !== 5'b00000) begin
        n_bad++;
        $display("FAIL post_rst[%0d]: got v=%b wxyz=%b err=%b, want v=0 wxyz=0000 err=0",
                 i, out_valid, {w, x, y, z}, err);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    dir      = 1'b0;
    {a, b, c, d} = 4'b0000;
    @(negedge clk);
    test_reset;
    test_back_to_back;
    test_illegal_fwd;
    test_xs3_to_bcd;
    test_round_trip;
    test_reset_midstream;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard: %0d results still pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
